// File: rtl/ctrl_env_responder_if.sv
// ctrl_env_responder_if: controller-side signals of the environment responder.
// Signals: Rreq/LEreq/sample are async requests and strobe; ack_dly/err_period are
// quasi-static config; Rack/LEack are 4-phase acks; Err0/Err1 form the dual-rail
// error codeword; tok_count/err_count/proto_err are status outputs.
interface ctrl_env_responder_if #(parameter int DLY_W = 4);
  logic             Rreq;
  logic             LEreq;
  logic             sample;
  logic [DLY_W-1:0] ack_dly;
  logic [3:0]       err_period;
  logic             Rack;
  logic             LEack;
  logic             Err0;
  logic             Err1;
  logic [15:0]      tok_count;
  logic [7:0]       err_count;
  logic             proto_err;
  modport master (output Rreq, LEreq, sample, ack_dly, err_period,
                  input Rack, LEack, Err0, Err1, tok_count, err_count, proto_err);
  modport slave (input Rreq, LEreq, sample, ack_dly, err_period,
                 output Rack, LEack, Err0, Err1, tok_count, err_count, proto_err);
endinterface

// File: rtl/ctrl_env_responder.sv
// ctrl_env_responder: acknowledges Rreq/LEreq handshakes and injects dual-rail timing errors.
// Ports: clk, rst (sync active-high), bus (slave modport carrying all handshake,
// config and status signals).
module ctrl_env_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DLY_W       = 4
) (
  input logic                 clk,
  input logic                 rst,
  ctrl_env_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_UP, ACK_HI, WAIT_DN} state_t;
  logic [SYNC_STAGES-1:0] r_rreq_sy, r_lereq_sy, r_smp_sy;
  state_t                 r_state, w_nxt;
  logic [DLY_W-1:0]       r_cnt, w_cnt;
  logic                   r_rack, w_rack, w_tok_inc, w_fsm_err;
  logic [15:0]            r_tok;
  logic                   r_le_d, r_le_d2, r_perr;
  logic                   r_smp_d, r_err0, r_err1;
  logic [3:0]             r_scnt;
  logic [7:0]             r_ecnt;
  logic                   w_rreq_s, w_le_s, w_smp_s, w_le_glitch, w_rise, w_fall, w_err;
  logic [3:0]             w_scnt;
  assign w_rreq_s    = r_rreq_sy[SYNC_STAGES-1];
  assign w_le_s      = r_lereq_sy[SYNC_STAGES-1];
  assign w_smp_s     = r_smp_sy[SYNC_STAGES-1];
  // two toggles on back-to-back cycles means LEreq_s held a level for only one cycle
  assign w_le_glitch = (w_le_s ^ r_le_d) & (r_le_d ^ r_le_d2);
  assign w_rise      = w_smp_s & ~r_smp_d;
  assign w_fall      = ~w_smp_s & r_smp_d;
  assign w_err       = (bus.err_period != 4'd0) && (r_scnt == bus.err_period - 4'd1);
  // a counter at or beyond the period (including a period lowered under it) wraps to 0
  assign w_scnt      = (r_scnt + 4'd1 >= bus.err_period) ? 4'd0 : r_scnt + 4'd1;
  always_comb begin
    w_nxt     = r_state;
    w_cnt     = r_cnt;
    w_rack    = r_rack;
    w_tok_inc = 1'b0;
    w_fsm_err = 1'b0;
    case (r_state)
      IDLE: if (w_rreq_s) begin
        w_nxt = WAIT_UP;
        w_cnt = bus.ack_dly;
      end
      WAIT_UP: if (!w_rreq_s) begin
        w_nxt     = IDLE;
        w_fsm_err = 1'b1;
      end else if (r_cnt == '0) begin
        w_nxt  = ACK_HI;
        w_rack = 1'b1;
      end else w_cnt = r_cnt - 1'b1;
      ACK_HI: if (!w_rreq_s) begin
        w_nxt = WAIT_DN;
        w_cnt = bus.ack_dly;
      end
      WAIT_DN: if (r_cnt == '0) begin
        w_nxt     = IDLE;
        w_rack    = 1'b0;
        w_tok_inc = 1'b1;
      end else w_cnt = r_cnt - 1'b1;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rreq_sy  <= '0;
      r_lereq_sy <= '0;
      r_smp_sy   <= '0;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rack     <= 1'b0;
      r_tok      <= 16'd0;
      r_le_d     <= 1'b0;
      r_le_d2    <= 1'b0;
      r_perr     <= 1'b0;
      r_smp_d    <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_scnt     <= 4'd0;
      r_ecnt     <= 8'd0;
    end else begin
      r_rreq_sy  <= {r_rreq_sy[SYNC_STAGES-2:0], bus.Rreq};
      r_lereq_sy <= {r_lereq_sy[SYNC_STAGES-2:0], bus.LEreq};
      r_smp_sy   <= {r_smp_sy[SYNC_STAGES-2:0], bus.sample};
      r_state    <= w_nxt;
      r_cnt      <= w_cnt;
      r_rack     <= w_rack;
      r_tok      <= w_tok_inc ? r_tok + 16'd1 : r_tok;
      r_le_d     <= w_le_s;
      r_le_d2    <= r_le_d;
      r_perr     <= r_perr | w_fsm_err | w_le_glitch;
      r_smp_d    <= w_smp_s;
      if (w_rise) begin
        r_scnt <= w_scnt;
        r_err1 <= w_err;
        r_err0 <= ~w_err;
        r_ecnt <= (w_err && r_ecnt != 8'hFF) ? r_ecnt + 8'd1 : r_ecnt;
      end else if (w_fall) begin
        r_err1 <= 1'b0;
        r_err0 <= 1'b0;
      end
    end
  end
  assign bus.Rack      = r_rack;
  assign bus.LEack     = r_le_d;
  assign bus.Err0      = r_err0;
  assign bus.Err1      = r_err1;
  assign bus.tok_count = r_tok;
  assign bus.err_count = r_ecnt;
  assign bus.proto_err = r_perr;
endmodule

// File: tb/tb_ctrl_env_responder.sv
// tb_ctrl_env_responder: scoreboard bench for ctrl_env_responder.
module tb_ctrl_env_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ctrl_env_responder_if #(.DLY_W(4)) bus();
  ctrl_env_responder #(.SYNC_STAGES(2), .DLY_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int cyc; int val;} ev_t;
  ev_t  rack_q[$], le_q[$], err_q[$];
  int   cyc = 0, total = 0, passed = 0;
  logic both_seen = 1'b0;
  logic p_rack = 1'b0, p_le = 1'b0;
  logic [1:0] p_err = 2'b00;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    ev_t e;
    if ({bus.Err1, bus.Err0} === 2'b11) both_seen = 1'b1;
    if (bus.Rack !== p_rack) begin
      if (rack_q.size() == 0) chk("rack_unexpected", int'(bus.Rack), -1);
      else begin
        e = rack_q.pop_front();
        chk("rack_cyc", cyc, e.cyc);
        chk("rack_val", int'(bus.Rack), e.val);
      end
      p_rack = bus.Rack;
    end
    if (bus.LEack !== p_le) begin
      if (le_q.size() == 0) chk("leack_unexpected", int'(bus.LEack), -1);
      else begin
        e = le_q.pop_front();
        chk("leack_cyc", cyc, e.cyc);
        chk("leack_val", int'(bus.LEack), e.val);
      end
      p_le = bus.LEack;
    end
    if ({bus.Err1, bus.Err0} !== p_err) begin
      if (err_q.size() == 0) chk("err_unexpected", int'({bus.Err1, bus.Err0}), -1);
      else begin
        e = err_q.pop_front();
        chk("err_cyc", cyc, e.cyc);
        chk("err_word", int'({bus.Err1, bus.Err0}), e.val);
      end
      p_err = {bus.Err1, bus.Err0};
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_rack(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    rack_q.push_back(e);
  endtask
  task automatic push_le(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    le_q.push_back(e);
  endtask
  task automatic push_err(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    err_q.push_back(e);
  endtask
  task automatic wait_rack(input logic v);
    for (int i = 0; i < 80 && bus.Rack !== v; i++) @(negedge clk);
    if (bus.Rack !== v) chk("rack_timeout", int'(bus.Rack), int'(v));
  endtask
  // Rreq driven after a falling edge: 2 sync edges, 1 FSM entry edge, then d+1 edges.
  task automatic hs(input int d, input int chg);
    bus.ack_dly = 4'(d);
    push_rack(cyc + 4 + d, 1);
    bus.Rreq = 1'b1;
    tick(4);
    bus.ack_dly = 4'(chg);
    wait_rack(1'b1);
    tick(1);
    bus.ack_dly = 4'(d);
    push_rack(cyc + 4 + d, 0);
    bus.Rreq = 1'b0;
    tick(4);
    bus.ack_dly = 4'(chg);
    wait_rack(1'b0);
    tick(2);
  endtask
  // sample rise/fall show up on Err rails 3 edges later (2 sync + edge detect register).
  task automatic spulse(input int word, input int hl);
    push_err(cyc + 3, word);
    bus.sample = 1'b1;
    tick(hl);
    push_err(cyc + 3, 0);
    bus.sample = 1'b0;
    tick(hl);
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d reached time limit, required finish", cyc);
    $fatal(1);
  end
  initial begin
    int c;
    bus.Rreq = 1'b0;
    bus.LEreq = 1'b0;
    bus.sample = 1'b0;
    bus.ack_dly = 4'd0;
    bus.err_period = 4'd0;
    tick(3);
    chk("rst_rack", int'(bus.Rack), 0);
    chk("rst_leack", int'(bus.LEack), 0);
    chk("rst_err0", int'(bus.Err0), 0);
    chk("rst_err1", int'(bus.Err1), 0);
    chk("rst_tok", int'(bus.tok_count), 0);
    chk("rst_ecnt", int'(bus.err_count), 0);
    chk("rst_perr", int'(bus.proto_err), 0);
    rst = 1'b0;
    tick(2);
    hs(0, 0);
    chk("tok_after_first", int'(bus.tok_count), 1);
    hs(0, 0);
    chk("tok_after_second", int'(bus.tok_count), 2);
    push_rack(cyc + 4, 1);
    bus.Rreq = 1'b1;
    wait_rack(1'b1);
    tick(1);
    push_rack(cyc + 1, 0);
    rst = 1'b1;
    tick(1);
    chk("midrst_tok", int'(bus.tok_count), 0);
    chk("midrst_rack", int'(bus.Rack), 0);
    chk("midrst_perr", int'(bus.proto_err), 0);
    rst = 1'b0;
    push_rack(cyc + 4, 1);
    wait_rack(1'b1);
    tick(1);
    push_rack(cyc + 4, 0);
    bus.Rreq = 1'b0;
    wait_rack(1'b0);
    tick(2);
    chk("tok_after_rst_hs", int'(bus.tok_count), 1);
    hs(5, 5);
    hs(5, 1);
    hs(5, 5);
    hs(5, 5);
    chk("tok_dly5", int'(bus.tok_count), 5);
    chk("perr_dly5", int'(bus.proto_err), 0);
    rst_pulse();
    bus.ack_dly = 4'd7;
    bus.Rreq = 1'b1;
    tick(5);
    bus.Rreq = 1'b0;
    tick(12);
    chk("abort_perr", int'(bus.proto_err), 1);
    chk("abort_rack", int'(bus.Rack), 0);
    chk("abort_tok", int'(bus.tok_count), 0);
    hs(0, 0);
    chk("abort_next_tok", int'(bus.tok_count), 1);
    bus.ack_dly = 4'd5;
    push_rack(cyc + 9, 1);
    bus.Rreq = 1'b1;
    wait_rack(1'b1);
    tick(1);
    c = cyc;
    push_rack(c + 9, 0);
    push_rack(c + 16, 1);
    bus.Rreq = 1'b0;
    tick(4);
    bus.Rreq = 1'b1;
    wait_rack(1'b0);
    wait_rack(1'b1);
    tick(1);
    push_rack(cyc + 9, 0);
    bus.Rreq = 1'b0;
    wait_rack(1'b0);
    tick(2);
    chk("waitdn_rereq_tok", int'(bus.tok_count), 3);
    chk("perr_sticky", int'(bus.proto_err), 1);
    rst_pulse();
    push_le(cyc + 3, 1);
    bus.LEreq = 1'b1;
    tick(6);
    push_le(cyc + 3, 0);
    bus.LEreq = 1'b0;
    tick(6);
    chk("le_clean_perr", int'(bus.proto_err), 0);
    push_le(cyc + 3, 1);
    push_le(cyc + 4, 0);
    bus.LEreq = 1'b1;
    tick(1);
    bus.LEreq = 1'b0;
    tick(6);
    chk("le_glitch_perr", int'(bus.proto_err), 1);
    rst_pulse();
    bus.err_period = 4'd3;
    for (int i = 1; i <= 9; i++) spulse((i % 3 == 0) ? 2 : 1, 4);
    chk("ecnt_p3", int'(bus.err_count), 3);
    spulse(1, 4);
    spulse(1, 4);
    bus.err_period = 4'd2;
    spulse(1, 4);
    spulse(1, 4);
    spulse(2, 4);
    chk("ecnt_period_drop", int'(bus.err_count), 4);
    rst_pulse();
    bus.err_period = 4'd0;
    for (int i = 0; i < 300; i++) spulse(1, 4);
    chk("ecnt_p0", int'(bus.err_count), 0);
    bus.err_period = 4'd1;
    for (int i = 0; i < 260; i++) spulse(2, 3);
    chk("ecnt_sat", int'(bus.err_count), 255);
    tick(4);
    chk("dual_rail_exclusive", int'(both_seen), 0);
    chk("rack_q_drained", rack_q.size(), 0);
    chk("le_q_drained", le_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
